// File: rtl/emif_rr_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter for the EMIF port: round-robin command grant, write bursts locked, in-order read tag FIFO.
// Latency: 1 cycle arbitration (IDLE->GRANT), command then passes combinationally; read data/valid routed back with 0 latency.
// Backpressure: granted master sees avs_waitrequest, other master held stalled; reads held off while MAX_OUTSTANDING reads are in flight.
//
// Ports: clk/SoftReset_n (async active-low); m0_*/m1_* Avalon-MM master-side command ports with
// mN_waitrequest/mN_readdatavalid; m_readdata shared read data; avs_* Avalon-MM slave-side (EMIF) port;
// err_stray_rdv sticky flag for a read beat arriving with no read outstanding.
module emif_rr_arbiter #(
    parameter int DDR_ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_WIDTH     = 12,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                      clk,
    input  logic                      SoftReset_n,
    input  logic [DDR_ADDR_WIDTH-1:0] m0_address,
    input  logic                      m0_read,
    input  logic                      m0_write,
    input  logic [DATA_WIDTH-1:0]     m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
    input  logic [BURST_WIDTH-1:0]    m0_burstcount,
    output logic                      m0_waitrequest,
    output logic                      m0_readdatavalid,
    input  logic [DDR_ADDR_WIDTH-1:0] m1_address,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [DATA_WIDTH-1:0]     m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
    input  logic [BURST_WIDTH-1:0]    m1_burstcount,
    output logic                      m1_waitrequest,
    output logic                      m1_readdatavalid,
    output logic [DATA_WIDTH-1:0]     m_readdata,
    output logic [DDR_ADDR_WIDTH-1:0] avs_address,
    output logic                      avs_read,
    output logic                      avs_write,
    output logic [DATA_WIDTH-1:0]     avs_writedata,
    output logic [DATA_WIDTH/8-1:0]   avs_byteenable,
    output logic [BURST_WIDTH-1:0]    avs_burstcount,
    input  logic                      avs_waitrequest,
    input  logic                      avs_readdatavalid,
    input  logic [DATA_WIDTH-1:0]     avs_readdata,
    output logic                      err_stray_rdv
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [BURST_WIDTH-1:0] BC_ONE = BURST_WIDTH'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WBURST} state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [BURST_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                   err_q, err_d;

    // Tag FIFO storage: issuing master and effective burst length per read in flight.
    logic                   fifo_id_mem  [MAX_OUTSTANDING];
    logic [BURST_WIDTH-1:0] fifo_len_mem [MAX_OUTSTANDING];

    logic                      g_read, g_write, g_wait;
    logic [BURST_WIDTH-1:0]    g_bc, g_bc_eff;
    logic                      fifo_full, fifo_empty, push, pop, rdv_hit, head_id;
    logic [BURST_WIDTH-1:0]    head_len;
    logic                      el0, el1, accepted;

    assign fifo_full  = (fifo_cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign el0        = m0_write | (m0_read & ~fifo_full);
    assign el1        = m1_write | (m1_read & ~fifo_full);
    assign accepted   = (avs_read | avs_write) & ~avs_waitrequest;

    // Command mux follows the registered grant; a burstcount of 0 is issued as 1.
    always_comb begin
        g_read         = grant_q ? m1_read       : m0_read;
        g_write        = grant_q ? m1_write      : m0_write;
        g_bc           = grant_q ? m1_burstcount : m0_burstcount;
        avs_address    = grant_q ? m1_address    : m0_address;
        avs_writedata  = grant_q ? m1_writedata  : m0_writedata;
        avs_byteenable = grant_q ? m1_byteenable : m0_byteenable;
        g_bc_eff       = (g_bc == '0) ? BC_ONE : g_bc;
        avs_burstcount = g_bc_eff;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        avs_read     = 1'b0;
        avs_write    = 1'b0;
        g_wait       = 1'b1;
        push         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (el0 && el1) grant_d = ~last_grant_q;
                else if (el0)   grant_d = 1'b0;
                else if (el1)   grant_d = 1'b1;
                if (el0 || el1) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (g_write) begin
                    avs_write = 1'b1;
                    g_wait    = avs_waitrequest;
                    if (accepted) begin
                        if (g_bc_eff > BC_ONE) begin
                            beat_cnt_d = g_bc_eff - BC_ONE;
                            state_d    = ST_WBURST;
                        end else begin
                            last_grant_d = grant_q;
                            state_d      = ST_IDLE;
                        end
                    end
                end else if (g_read && !fifo_full) begin
                    avs_read = 1'b1;
                    g_wait   = avs_waitrequest;
                    if (accepted) begin
                        push         = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end else if (!g_read) begin
                    // Granted master withdrew its request; re-arbitrate rather than lock up.
                    state_d = ST_IDLE;
                end
            end
            ST_WBURST: begin
                // Only write beats pass; a read from the burst owner stays stalled.
                avs_write = g_write;
                g_wait    = g_write ? avs_waitrequest : 1'b1;
                if (accepted) begin
                    if (beat_cnt_q == BC_ONE) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - BC_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (grant_q) m1_waitrequest = g_wait;
        else         m0_waitrequest = g_wait;
    end

    // Read return: the FIFO head names the owner of every returning beat.
    assign head_id  = fifo_id_mem[rd_ptr_q];
    assign head_len = fifo_len_mem[rd_ptr_q];
    assign rdv_hit  = avs_readdatavalid & ~fifo_empty;
    assign pop      = rdv_hit & (rd_cnt_q == head_len - BC_ONE);

    assign m0_readdatavalid = rdv_hit & ~head_id;
    assign m1_readdatavalid = rdv_hit &  head_id;
    assign m_readdata       = avs_readdata;
    assign err_stray_rdv    = err_q;

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        if (pop)          rd_cnt_d = '0;
        else if (rdv_hit) rd_cnt_d = rd_cnt_q + BC_ONE;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        err_d      = err_q | (avs_readdatavalid & fifo_empty);
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_mem[wr_ptr_q]  <= grant_q;
            fifo_len_mem[wr_ptr_q] <= g_bc_eff;
        end
    end

endmodule

// File: tb/tb_emif_rr_arbiter.sv
// Bench for emif_rr_arbiter: directed master traffic, latency-3 slave model, response scoreboard.
// Latency: n/a.
// Backpressure: slave can inject waitrequest and withhold read data.
module tb_emif_rr_arbiter;

    localparam int AW = 26;
    localparam int DW = 64;
    localparam int BW = 12;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [AW-1:0]   m_addr [2];
    logic            m_rd   [2];
    logic            m_wr   [2];
    logic [DW-1:0]   m_wd   [2];
    logic [DW/8-1:0] m_be   [2];
    logic [BW-1:0]   m_bc   [2];
    logic            m_wait0, m_wait1, m_rdv0, m_rdv1;
    logic [DW-1:0]   m_rdata;
    logic [AW-1:0]   avs_address;
    logic            avs_read, avs_write;
    logic [DW-1:0]   avs_writedata;
    logic [DW/8-1:0] avs_byteenable;
    logic [BW-1:0]   avs_burstcount;
    logic            avs_wait = 1'b0;
    logic            avs_rdv = 1'b0;
    logic [DW-1:0]   avs_rdata = '0;
    logic            err;

    emif_rr_arbiter #(.DDR_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .SoftReset_n(rst_n),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_writedata(m_wd[0]),
        .m0_byteenable(m_be[0]), .m0_burstcount(m_bc[0]), .m0_waitrequest(m_wait0), .m0_readdatavalid(m_rdv0),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_writedata(m_wd[1]),
        .m1_byteenable(m_be[1]), .m1_burstcount(m_bc[1]), .m1_waitrequest(m_wait1), .m1_readdatavalid(m_rdv1),
        .m_readdata(m_rdata),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable), .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_wait),
        .avs_readdatavalid(avs_rdv), .avs_readdata(avs_rdata), .err_stray_rdv(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_pat(input logic [AW-1:0] a, input int b);
        return {6'h2A, a, b[31:0]};
    endfunction

    function automatic logic [63:0] wr_pat(input int n, input logic [AW-1:0] a, input int b);
        return {4'hA, 4'(n), a[23:0], b[31:0]};
    endfunction

    // Scoreboard of expected read beats, in the order commands were accepted.
    typedef struct {int id; logic [63:0] data;} rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_r;

    int rdv_cnt [2];
    int wbeat   [2];
    int acc_cnt [2];
    int acc_cyc [2];
    int req_cyc [2];
    int acc_log [$];
    int rd_hi_cnt = 0;
    int last_rd_cyc = 0;
    int last_rdv_cyc = 0;
    int last_wr_cyc = 0;
    int t3_on = 0;
    int t3_base = 0;
    int t3_viol = 0;
    bit abort = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (avs_read) begin
                rd_hi_cnt++;
                last_rd_cyc = cyc;
            end
            if (t3_on != 0 && !m_wait0 && (wbeat[1] - t3_base) < 4) t3_viol++;
            if (avs_write && !avs_wait) begin
                wbeat[avs_writedata[56]]++;
                last_wr_cyc = cyc;
            end
            if (m_rdv0 && m_rdv1) chk("rdv_both", 64'({m_rdv1, m_rdv0}), 64'd1);
            if (m_rdv0 || m_rdv1) begin
                last_rdv_cyc = cyc;
                if (m_rdv1) rdv_cnt[1]++;
                else        rdv_cnt[0]++;
                if (exp_q.size() == 0) begin
                    chk("rdv_unexpected", 64'({m_rdv1, m_rdv0}), 64'd0);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("rsp_route", 64'(m_rdv1), 64'(mon_r.id));
                    chk("rsp_data", m_rdata, mon_r.data);
                end
            end
        end
    end

    // Slave: first read beat 3 cycles after acceptance, then back-to-back; sl_hold withholds data.
    typedef struct {int rdy; logic [63:0] d;} beat_t;
    beat_t sl_q[$];
    beat_t sl_b;
    bit    sl_hold = 1'b0;

    always @(negedge clk) begin
        if (rst_n && avs_read && !avs_wait) begin
            for (int b = 0; b < int'(avs_burstcount); b++)
                sl_q.push_back('{rdy: cyc + 3, d: rd_pat(avs_address, b)});
        end
    end

    always @(posedge clk) begin
        #1;
        if (!sl_hold && sl_q.size() > 0 && sl_q[0].rdy <= cyc) begin
            sl_b      = sl_q.pop_front();
            avs_rdv   = 1'b1;
            avs_rdata = sl_b.d;
        end else begin
            avs_rdv = 1'b0;
        end
    end

    // Master n issues ncmd back-to-back commands (addresses base+i), holding its request between them.
    task automatic mst_run(input int n, input bit wr, input logic [AW-1:0] base, input int bc, input int ncmd);
        int nb, t;
        bit ok;
        logic [AW-1:0] a;
        nb = (bc == 0) ? 1 : bc;
        @(posedge clk); #1;
        req_cyc[n] = cyc;
        for (int i = 0; i < ncmd; i++) begin
            a = base + AW'(i);
            for (int b = 0; b < (wr ? nb : 1); b++) begin
                m_addr[n] = a;
                m_bc[n]   = BW'(bc);
                m_wd[n]   = wr_pat(n, a, b);
                m_be[n]   = '1;
                m_rd[n]   = !wr;
                m_wr[n]   = wr;
                ok = 1'b0;
                t  = 0;
                while (!ok && t < 300 && !abort) begin
                    @(negedge clk);
                    ok = (n == 0) ? !m_wait0 : !m_wait1;
                    t++;
                end
                if (abort) begin
                    m_rd[n] = 1'b0;
                    m_wr[n] = 1'b0;
                    return;
                end
                chk($sformatf("m%0d_accept", n), 64'(ok), 64'd1);
                if (!ok) begin
                    m_rd[n] = 1'b0;
                    m_wr[n] = 1'b0;
                    return;
                end
                if (!wr) begin
                    for (int k = 0; k < nb; k++) exp_q.push_back('{id: n, data: rd_pat(a, k)});
                end
                if (!wr || b == nb - 1) begin
                    acc_cnt[n]++;
                    acc_cyc[n] = cyc;
                    acc_log.push_back(n);
                end
                @(posedge clk); #1;
            end
        end
        m_rd[n] = 1'b0;
        m_wr[n] = 1'b0;
    endtask

    task automatic wait_rdv(input int n, input int target, input string tag);
        int t;
        t = 0;
        while (rdv_cnt[n] < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 64'(rdv_cnt[n]), 64'(target));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk({tag, "_avs_read"},  64'(avs_read),  64'd0);
        chk({tag, "_avs_write"}, 64'(avs_write), 64'd0);
        chk({tag, "_m0_wait"},   64'(m_wait0),   64'd1);
        chk({tag, "_m1_wait"},   64'(m_wait1),   64'd1);
        chk({tag, "_rdv"},       64'({m_rdv1, m_rdv0}), 64'd0);
        chk({tag, "_err"},       64'(err),       64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int r0, r1, a0, rdh, rel_cyc, wb;

    initial begin
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = '0; m_rd[n] = 1'b0; m_wr[n] = 1'b0;
            m_wd[n] = '0; m_be[n] = '0; m_bc[n] = '0;
            rdv_cnt[n] = 0; wbeat[n] = 0; acc_cnt[n] = 0; acc_cyc[n] = 0; req_cyc[n] = 0;
        end
        #2;
        do_reset("rst");

        // 1: single m0 read, slave latency 3.
        rdh = rd_hi_cnt; r0 = rdv_cnt[0]; r1 = rdv_cnt[1];
        mst_run(0, 1'b0, AW'('h10), 1, 1);
        wait_rdv(0, r0 + 1, "t1_m0_rdv");
        repeat (5) @(negedge clk);
        chk("t1_read_pulses", 64'(rd_hi_cnt - rdh), 64'd1);
        chk("t1_arb_latency", 64'(last_rd_cyc - req_cyc[0]), 64'd1);
        chk("t1_rsp_latency", 64'(last_rdv_cyc - last_rd_cyc), 64'd3);
        chk("t1_m1_rdv", 64'(rdv_cnt[1] - r1), 64'd0);

        // 2: both masters hold reads from a fresh reset -> m0,m1,m0,m1.
        do_reset("rst2");
        acc_log.delete();
        r0 = rdv_cnt[0]; r1 = rdv_cnt[1];
        fork
            mst_run(0, 1'b0, AW'('h100), 1, 2);
            mst_run(1, 1'b0, AW'('h200), 1, 2);
        join
        chk("t2_grants", 64'(acc_log.size()), 64'd4);
        for (int i = 0; i < acc_log.size() && i < 4; i++)
            chk($sformatf("t2_grant%0d", i), 64'(acc_log[i]), 64'(i % 2));
        wait_rdv(0, r0 + 2, "t2_m0_rdv");
        wait_rdv(1, r1 + 2, "t2_m1_rdv");

        // 3: m1 4-beat write with 2 stall cycles, m0 read arrives mid-burst.
        t3_base = wbeat[1]; t3_viol = 0; t3_on = 1;
        r0 = rdv_cnt[0];
        fork
            mst_run(1, 1'b1, AW'('h300), 4, 1);
            begin
                repeat (2) @(posedge clk);
                #1 avs_wait = 1'b1;
                repeat (2) @(posedge clk);
                #1 avs_wait = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                mst_run(0, 1'b0, AW'('h400), 1, 1);
            end
        join
        t3_on = 0;
        chk("t3_write_beats", 64'(wbeat[1] - t3_base), 64'd4);
        chk("t3_m0_stalled", 64'(t3_viol), 64'd0);
        chk("t3_m0_grant_gap", 64'(acc_cyc[0] - last_wr_cyc), 64'd2);
        wait_rdv(0, r0 + 1, "t3_m0_rdv");

        // 4: tag FIFO full (4 reads, data withheld) -> 5th read stalls, m1 write still served.
        sl_hold = 1'b1;
        a0 = acc_cnt[0]; r0 = rdv_cnt[0]; wb = wbeat[1];
        fork
            mst_run(0, 1'b0, AW'('h500), 1, 5);
            begin
                repeat (12) @(posedge clk);
                chk("t4_reads_in_flight", 64'(acc_cnt[0] - a0), 64'd4);
                rdh = rd_hi_cnt;
                mst_run(1, 1'b1, AW'('h600), 1, 1);
                repeat (3) @(posedge clk);
                chk("t4_m1_write", 64'(wbeat[1] - wb), 64'd1);
                chk("t4_read_held", 64'(rd_hi_cnt - rdh), 64'd0);
                chk("t4_fifth_pending", 64'(acc_cnt[0] - a0), 64'd4);
                @(negedge clk);
                rel_cyc = cyc;
                sl_hold = 1'b0;
            end
        join
        chk("t4_fifth_accepted", 64'(acc_cnt[0] - a0), 64'd5);
        chk("t4_fifth_after_rdv", 64'((acc_cyc[0] - rel_cyc) >= 2), 64'd1);
        wait_rdv(0, r0 + 5, "t4_m0_rdv");

        // 5: m0 8-beat read then m1 2-beat read; scoreboard enforces ordering.
        r0 = rdv_cnt[0]; r1 = rdv_cnt[1];
        fork
            mst_run(0, 1'b0, AW'('h700), 8, 1);
            begin
                @(posedge clk);
                mst_run(1, 1'b0, AW'('h800), 2, 1);
            end
        join
        wait_rdv(0, r0 + 8, "t5_m0_rdv");
        wait_rdv(1, r1 + 2, "t5_m1_rdv");
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_no_stray", 64'(err), 64'd0);

        // 6: reset during beat 2 of a write burst with one read outstanding.
        sl_hold = 1'b1;
        mst_run(0, 1'b0, AW'('h900), 1, 1);
        wb = wbeat[1];
        fork
            mst_run(1, 1'b1, AW'('hA00), 4, 1);
            begin
                for (int t = 0; t < 100 && wbeat[1] < wb + 1; t++) @(negedge clk);
                @(posedge clk); #2;
                chk("t6_beat2_live", 64'(avs_write), 64'd1);
                rst_n = 1'b0;
                abort = 1'b1;
                exp_q.delete();
                #1;
                chk("t6_avs_write", 64'(avs_write), 64'd0);
                chk("t6_m0_wait", 64'(m_wait0), 64'd1);
                chk("t6_m1_wait", 64'(m_wait1), 64'd1);
            end
        join
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        abort = 1'b0;
        r0 = rdv_cnt[0]; r1 = rdv_cnt[1];
        @(negedge clk);
        sl_hold = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_err_stray", 64'(err), 64'd1);
        chk("t6_no_rdv", 64'((rdv_cnt[0] - r0) + (rdv_cnt[1] - r1)), 64'd0);
        chk("t6_slave_drained", 64'(sl_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emif_rr_arbiter.md
Name: emif_rr_arbiter

Overview:
Two-master, one-slave Avalon-MM arbiter that shares the single EMIF (DDR) Avalon-MM port between two requesters, for example the CSR-driven test FSM and a traffic generator. Command grants are round-robin. Write bursts are locked to the master that started them. Read responses are routed back to the issuing master through an in-order tag FIFO. The block sits between the masters and the EMIF interface, inside the AFU clock domain.

Parameters:
DDR_ADDR_WIDTH, 26, word address width.
DATA_WIDTH, 512, data bus width; byteenable width is DATA_WIDTH/8.
BURST_WIDTH, 12, burstcount width.
MAX_OUTSTANDING, 16, read tag FIFO depth (number of read commands in flight); power of 2.

Ports:
clk  in  1  single clock.
SoftReset_n  in  1  asynchronous, active-low reset.
mN_address (N=0,1)  in  DDR_ADDR_WIDTH  master N address.
mN_read / mN_write  in  1 each  master N command.
mN_writedata  in  DATA_WIDTH  master N write data.
mN_byteenable  in  DATA_WIDTH/8  master N byte enables.
mN_burstcount  in  BURST_WIDTH  master N burst length.
mN_waitrequest  out  1  stall to master N.
mN_readdatavalid  out  1  read beat for master N.
m_readdata  out  DATA_WIDTH  read data, shared by both masters (equals avs_readdata).
avs_address  out  DDR_ADDR_WIDTH  to EMIF.
avs_read / avs_write  out  1 each  to EMIF.
avs_writedata  out  DATA_WIDTH  to EMIF.
avs_byteenable  out  DATA_WIDTH/8  to EMIF.
avs_burstcount  out  BURST_WIDTH  to EMIF.
avs_waitrequest  in  1  EMIF stall.
avs_readdatavalid  in  1  EMIF read beat.
avs_readdata  in  DATA_WIDTH  EMIF read data.
err_stray_rdv  out  1  sticky flag: readdatavalid arrived while the tag FIFO was empty.

Behaviour:
- Reset (async assert, sync deassert handled upstream). State=IDLE; last_grant=1, so m0 wins the first tie. Tag FIFO is emptied and beat counters are cleared. Outputs: avs_read=0, avs_write=0, mN_waitrequest=1, mN_readdatavalid=0, err_stray_rdv=0.
- A command is "accepted" in a cycle when (avs_read|avs_write) and !avs_waitrequest.
- FSM, IDLE:
  - All mN_waitrequest=1; avs_read/avs_write=0.
  - An eligible request is mN_write, or mN_read with the FIFO not full.
  - If both masters are eligible, grant the master that is not last_grant; otherwise grant the single eligible master.
  - Register grant and go to GRANT. Arbitration latency is 1 cycle.
- FSM, GRANT:
  - The granted master's command signals are muxed combinationally to avs_*.
  - Granted mN_waitrequest = avs_waitrequest. The other master is held at 1.
  - On an accepted read: push {grant, burstcount} into the FIFO, set last_grant=grant, go to IDLE.
  - On an accepted write with burstcount<=1: set last_grant, go to IDLE.
  - On an accepted write with burstcount>1: load beat_cnt=burstcount-1, go to WBURST.
  - If the FIFO becomes full while a read is granted, avs_read is held at 0 and the master stays stalled. Full is evaluated before any same-cycle pop; no bypass.
- FSM, WBURST:
  - Forward only the granted master's write beats. The other master is stalled.
  - Decrement beat_cnt on each accepted beat. Bubbles (mN_write=0) are allowed.
  - When the beat with beat_cnt==1 is accepted: set last_grant, go to IDLE.
  - Reads from either master are not forwarded during WBURST.
- burstcount==0 is treated as 1.
- Read return path:
  - The FIFO head gives {id, len}; rd_cnt counts beats of the head entry.
  - Each avs_readdatavalid asserts m<id>_readdatavalid in the same cycle (combinational, 0 latency). m_readdata=avs_readdata.
  - When rd_cnt reaches len-1 and a beat arrives: pop the FIFO and clear rd_cnt.
  - A push and pop in the same cycle are both honoured; the count is unchanged.
  - readdatavalid with the FIFO empty: no mN_readdatavalid; set err_stray_rdv (cleared only by reset).
- Responses return in command order, as Avalon guarantees, so no reordering logic is needed.
- Reset mid-burst or with reads in flight: everything is cleared immediately. Responses still returning from the EMIF afterward hit an empty FIFO and set err_stray_rdv.
- Widths: beat_cnt and rd_cnt are BURST_WIDTH bits. The FIFO count is log2(MAX_OUTSTANDING)+1 bits.

Test Plan:
1. m0 single read (addr 0x10, burstcount 1), slave latency 3, avs_waitrequest=0 -> avs_read high 1 cycle, 1 cycle after request. m0_readdatavalid pulses once, 3 cycles later, with m_readdata equal to slave data. m1_readdatavalid stays 0.
2. m0 and m1 both hold single reads for 4 grants -> grant order m0,m1,m0,m1. Responses route to m0,m1,m0,m1.
3. m1 write, burstcount 4, with 2 slave waitrequest cycles inserted; m0 read requested mid-burst -> exactly 4 accepted write beats from m1. m0_waitrequest=1 until after the 4th beat; m0 read is issued in the next GRANT.
4. MAX_OUTSTANDING=4: m0 issues 4 reads, slave withholds data -> 5th read stalled (avs_read=0). m1 write is granted and completes. After the first readdatavalid, the 5th read is accepted.
5. m0 read burstcount 8, then m1 read burstcount 2 -> 8 m0_readdatavalid beats, then 2 m1_readdatavalid beats. FIFO is empty at the end.
6. SoftReset_n low during beat 2 of a write burst with 1 read outstanding -> avs_write=0 and waitrequests=1 asynchronously. A later readdatavalid sets err_stray_rdv=1, and no mN_readdatavalid asserts.
